// File: rtl/rf_ldst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_ldst_pkg
//  Description : Shared types and default widths for the queued, strided
//                RF load/store command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_ldst_pkg;

   localparam int DEF_RF_ADDR_W    = 10;
   localparam int DEF_LINE_NUM_W   = 8;
   localparam int DEF_SDRAM_ADDR_W = 32;
   localparam int DEF_STRIDE_W     = 16;
   localparam int DEF_QDEPTH       = 4;

   // Command layout as stored in the FIFO (default widths); the top packs
   // fields in this same order, is_store in the MSB.
   typedef struct packed {
      logic                        is_store;
      logic [DEF_RF_ADDR_W-1:0]    rf_addr;
      logic [DEF_SDRAM_ADDR_W-1:0] sdram_addr;
      logic [DEF_LINE_NUM_W-1:0]   line_num;
      logic [DEF_STRIDE_W-1:0]     stride;
   } rf_ldst_cmd_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } rf_ldst_state_e;

endpackage : rf_ldst_pkg
`default_nettype wire

// File: rtl/rf_ldst_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rf_ldst_cmd_fifo
//  Description : Generic synchronous FIFO, power-of-two depth, with
//                occupancy count. Head word is presented on o_rdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_ldst_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_push,
   input  logic [WIDTH-1:0]               i_wdata,
   input  logic                           i_pop,
   output logic [WIDTH-1:0]               o_rdata,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);

   localparam int C_AW = $clog2(DEPTH);
   localparam int C_CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [C_AW-1:0]  r_wr_ptr;
   logic [C_AW-1:0]  r_rd_ptr;
   logic [C_CW-1:0]  r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == C_CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage array; contents need no reset since the count guards reads.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + C_CW'(1);
            2'b01:   r_count <= r_count - C_CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : rf_ldst_cmd_fifo
`default_nettype wire

// File: rtl/rf_ldst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rf_ldst_sequencer
//  Description : Queues RF load/store commands and expands each one into
//                per-line requests (RF +1, SDRAM +stride per line) with a
//                req/ack handshake towards the RF/SDRAM mover.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_ldst_sequencer
   import rf_ldst_pkg::*;
#(
   parameter int RF_ADDR_W    = DEF_RF_ADDR_W,
   parameter int LINE_NUM_W   = DEF_LINE_NUM_W,
   parameter int SDRAM_ADDR_W = DEF_SDRAM_ADDR_W,
   parameter int STRIDE_W     = DEF_STRIDE_W,
   parameter int QDEPTH       = DEF_QDEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_is_store,
   input  logic [RF_ADDR_W-1:0]          cmd_rf_addr,
   input  logic [SDRAM_ADDR_W-1:0]       cmd_sdram_addr,
   input  logic [LINE_NUM_W-1:0]         cmd_line_num,
   input  logic [STRIDE_W-1:0]           cmd_stride,
   output logic                          line_req,
   output logic                          line_is_store,
   output logic [RF_ADDR_W-1:0]          line_rf_addr,
   output logic [SDRAM_ADDR_W-1:0]       line_sdram_addr,
   input  logic                          line_ack,
   output logic                          done,
   output logic                          done_is_store,
   output logic                          err_zero_len,
   output logic                          busy,
   output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

   localparam int C_CMD_W = 1 + RF_ADDR_W + SDRAM_ADDR_W + LINE_NUM_W + STRIDE_W;

   logic [C_CMD_W-1:0]      w_push_data;
   logic [C_CMD_W-1:0]      w_head;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_accept;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_line_adv;
   logic                    w_last;

   logic                    w_head_is_store;
   logic [RF_ADDR_W-1:0]    w_head_rf;
   logic [SDRAM_ADDR_W-1:0] w_head_sdram;
   logic [LINE_NUM_W-1:0]   w_head_num;
   logic [STRIDE_W-1:0]     w_head_stride;

   rf_ldst_state_e          r_state;
   rf_ldst_state_e          w_state_nxt;
   logic                    r_dir;
   logic [RF_ADDR_W-1:0]    r_cur_rf;
   logic [SDRAM_ADDR_W-1:0] r_cur_sdram;
   logic [LINE_NUM_W-1:0]   r_remaining;
   logic [STRIDE_W-1:0]     r_stride;
   logic                    r_done;
   logic                    r_done_is_store;
   logic                    r_err_zero;

   // Zero-length commands are handshaken but never occupy a FIFO slot.
   assign cmd_ready   = !w_full;
   assign w_accept    = cmd_valid && cmd_ready;
   assign w_push      = w_accept && (cmd_line_num != '0);
   assign w_push_data = {cmd_is_store, cmd_rf_addr, cmd_sdram_addr, cmd_line_num, cmd_stride};
   assign {w_head_is_store, w_head_rf, w_head_sdram, w_head_num, w_head_stride} = w_head;

   rf_ldst_cmd_fifo #(
      .WIDTH (C_CMD_W),
      .DEPTH (QDEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (w_push_data),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (q_count)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: pop in IDLE, step or finish a command on each accepted line.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_line_adv  = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (line_ack) begin
               if (r_remaining > LINE_NUM_W'(1)) begin
                  w_line_adv = 1'b1;
               end else begin
                  w_last      = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Current-line fields: loaded on pop, advanced on each non-final ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dir       <= 1'b0;
         r_cur_rf    <= '0;
         r_cur_sdram <= '0;
         r_remaining <= '0;
         r_stride    <= '0;
      end else if (w_pop) begin
         r_dir       <= w_head_is_store;
         r_cur_rf    <= w_head_rf;
         r_cur_sdram <= w_head_sdram;
         r_remaining <= w_head_num;
         r_stride    <= w_head_stride;
      end else if (w_line_adv) begin
         r_cur_rf    <= r_cur_rf + RF_ADDR_W'(1);
         r_cur_sdram <= r_cur_sdram + SDRAM_ADDR_W'(r_stride);
         r_remaining <= r_remaining - LINE_NUM_W'(1);
      end
   end

   // One-cycle status pulses: command completion and dropped zero-length command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done          <= 1'b0;
         r_done_is_store <= 1'b0;
         r_err_zero      <= 1'b0;
      end else begin
         r_done          <= w_last;
         r_done_is_store <= w_last ? r_dir : 1'b0;
         r_err_zero      <= w_accept && (cmd_line_num == '0);
      end
   end

   assign line_req        = (r_state == ISSUE);
   assign line_is_store   = r_dir;
   assign line_rf_addr    = r_cur_rf;
   assign line_sdram_addr = r_cur_sdram;
   assign done            = r_done;
   assign done_is_store   = r_done_is_store;
   assign err_zero_len    = r_err_zero;
   assign busy            = !w_empty || (r_state != IDLE);

endmodule : rf_ldst_sequencer
`default_nettype wire

// File: tb/tb_rf_ldst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_ldst_sequencer
//  Description : Self-checking bench for rf_ldst_sequencer: table vectors,
//                directed multi-cycle sequences and random traffic against a
//                queue-based command model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_ldst_sequencer;

   localparam int QD = 4;

   typedef struct packed {
      logic        st;
      logic [9:0]  rf;
      logic [31:0] sd;
      logic [7:0]  n;
      logic [15:0] stride;
   } cmd_t;

   typedef struct {
      logic        v;
      cmd_t        c;
      logic        a;
      logic        e_req;
      logic [9:0]  e_rf;
      logic [31:0] e_sd;
      logic        e_done;
      logic        e_dst;
      logic        e_err;
      int          e_qc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_is_store = 1'b0;
   logic [9:0]  cmd_rf_addr = '0;
   logic [31:0] cmd_sdram_addr = '0;
   logic [7:0]  cmd_line_num = '0;
   logic [15:0] cmd_stride = '0;
   logic        line_req;
   logic        line_is_store;
   logic [9:0]  line_rf_addr;
   logic [31:0] line_sdram_addr;
   logic        line_ack = 1'b0;
   logic        done;
   logic        done_is_store;
   logic        err_zero_len;
   logic        busy;
   logic [2:0]  q_count;

   always #5 clk = ~clk;

   rf_ldst_sequencer #(
      .RF_ADDR_W    (10),
      .LINE_NUM_W   (8),
      .SDRAM_ADDR_W (32),
      .STRIDE_W     (16),
      .QDEPTH       (QD)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_is_store    (cmd_is_store),
      .cmd_rf_addr     (cmd_rf_addr),
      .cmd_sdram_addr  (cmd_sdram_addr),
      .cmd_line_num    (cmd_line_num),
      .cmd_stride      (cmd_stride),
      .line_req        (line_req),
      .line_is_store   (line_is_store),
      .line_rf_addr    (line_rf_addr),
      .line_sdram_addr (line_sdram_addr),
      .line_ack        (line_ack),
      .done            (done),
      .done_is_store   (done_is_store),
      .err_zero_len    (err_zero_len),
      .busy            (busy),
      .q_count         (q_count)
   );

   int n_checks = 0;
   int n_err    = 0;
   int obs_ack  = 0;
   int obs_done = 0;

   // Reference model: pending queue plus the active command and line index.
   cmd_t mq[$];
   cmd_t m_cur;
   logic m_act;
   int   m_k;
   logic m_done;
   logic m_dst;
   logic m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cur  = '0;
      m_act  = 1'b0;
      m_k    = 0;
      m_done = 1'b0;
      m_dst  = 1'b0;
      m_err  = 1'b0;
   endtask

   // One clock edge of the model, applied with the inputs seen at that edge.
   task automatic model_step(input logic v, input cmd_t c, input logic a);
      logic acc;
      logic nd;
      logic ndst;
      acc  = v && (mq.size() < QD);
      nd   = 1'b0;
      ndst = 1'b0;
      if (m_act) begin
         if (a) begin
            m_k++;
            if (m_k == int'(m_cur.n)) begin
               m_act = 1'b0;
               nd    = 1'b1;
               ndst  = m_cur.st;
            end
         end
      end else if (mq.size() > 0) begin
         m_cur = mq.pop_front();
         m_k   = 0;
         m_act = 1'b1;
      end
      if (acc && c.n != 8'd0) mq.push_back(c);
      m_err  = acc && (c.n == 8'd0);
      m_done = nd;
      m_dst  = ndst;
   endtask

   task automatic compare_model();
      logic [9:0]  erf;
      logic [31:0] esd;
      erf = m_cur.rf + 10'(m_k);
      esd = m_cur.sd + 32'(m_k) * {16'h0, m_cur.stride};
      chk("line_req",     line_req,     m_act);
      chk("cmd_ready",    cmd_ready,    mq.size() < QD);
      chk("q_count",      q_count,      mq.size());
      chk("busy",         busy,         m_act || (mq.size() > 0));
      chk("done",         done,         m_done);
      chk("err_zero_len", err_zero_len, m_err);
      if (m_act) begin
         chk("line_rf_addr",    line_rf_addr,    erf);
         chk("line_sdram_addr", line_sdram_addr, esd);
         chk("line_is_store",   line_is_store,   m_cur.st);
      end
      if (m_done) chk("done_is_store", done_is_store, m_dst);
      if (done === 1'b1) obs_done++;
   endtask

   task automatic drive(input logic v, input cmd_t c, input logic a);
      cmd_valid      = v;
      cmd_is_store   = c.st;
      cmd_rf_addr    = c.rf;
      cmd_sdram_addr = c.sd;
      cmd_line_num   = c.n;
      cmd_stride     = c.stride;
      line_ack       = a;
   endtask

   // Drive one cycle of inputs, clock, then compare DUT against the model.
   task automatic cyc(input logic v, input cmd_t c, input logic a);
      drive(v, c, a);
      if (line_req && a) obs_ack++;
      @(posedge clk);
      model_step(v, c, a);
      #1;
      compare_model();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t tv[15];
      cmd_t ca, cw, cz, cr, cs, cl, cx;
      logic rdy, pushed, seen;

      ca = '{st:1'b0, rf:10'h010, sd:32'h0000_1000, n:8'd3,   stride:16'h0040};
      cw = '{st:1'b1, rf:10'h3FE, sd:32'hFFFF_FFC0, n:8'd3,   stride:16'h0020};
      cz = '{st:1'b0, rf:10'h055, sd:32'h0000_ABCD, n:8'd0,   stride:16'h0010};
      cr = '{st:1'b1, rf:10'h100, sd:32'h0000_2000, n:8'd5,   stride:16'h0008};
      cs = '{st:1'b1, rf:10'h200, sd:32'h0004_0000, n:8'd2,   stride:16'h0100};
      cl = '{st:1'b0, rf:10'h3F0, sd:32'h8000_0000, n:8'd255, stride:16'hFFFF};

      //           v     cmd a     req   rf      sd             done  dst   err   qc
      tv[0]  = '{1'b1, ca, 1'b1, 1'b0, 10'h0,   32'h0,         1'b0, 1'b0, 1'b0, 1};
      tv[1]  = '{1'b0, ca, 1'b1, 1'b1, 10'h010, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 0};
      tv[2]  = '{1'b0, ca, 1'b1, 1'b1, 10'h011, 32'h0000_1040, 1'b0, 1'b0, 1'b0, 0};
      tv[3]  = '{1'b0, ca, 1'b1, 1'b1, 10'h012, 32'h0000_1080, 1'b0, 1'b0, 1'b0, 0};
      tv[4]  = '{1'b0, ca, 1'b1, 1'b0, 10'h0,   32'h0,         1'b1, 1'b0, 1'b0, 0};
      tv[5]  = '{1'b0, ca, 1'b1, 1'b0, 10'h0,   32'h0,         1'b0, 1'b0, 1'b0, 0};
      tv[6]  = '{1'b1, cw, 1'b1, 1'b0, 10'h0,   32'h0,         1'b0, 1'b0, 1'b0, 1};
      tv[7]  = '{1'b0, cw, 1'b1, 1'b1, 10'h3FE, 32'hFFFF_FFC0, 1'b0, 1'b0, 1'b0, 0};
      tv[8]  = '{1'b0, cw, 1'b1, 1'b1, 10'h3FF, 32'hFFFF_FFE0, 1'b0, 1'b0, 1'b0, 0};
      tv[9]  = '{1'b0, cw, 1'b1, 1'b1, 10'h000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0};
      tv[10] = '{1'b0, cw, 1'b1, 1'b0, 10'h0,   32'h0,         1'b1, 1'b1, 1'b0, 0};
      tv[11] = '{1'b0, cw, 1'b0, 1'b0, 10'h0,   32'h0,         1'b0, 1'b0, 1'b0, 0};
      tv[12] = '{1'b1, cz, 1'b0, 1'b0, 10'h0,   32'h0,         1'b0, 1'b0, 1'b1, 0};
      tv[13] = '{1'b0, cz, 1'b0, 1'b0, 10'h0,   32'h0,         1'b0, 1'b0, 1'b0, 0};
      tv[14] = '{1'b0, cz, 1'b1, 1'b0, 10'h0,   32'h0,         1'b0, 1'b0, 1'b0, 0};

      // Reset values
      drive(1'b0, ca, 1'b0);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready",     cmd_ready,       1'b1);
      chk("rst_line_req",      line_req,        1'b0);
      chk("rst_line_is_store", line_is_store,   1'b0);
      chk("rst_rf_addr",       line_rf_addr,    10'h0);
      chk("rst_sdram_addr",    line_sdram_addr, 32'h0);
      chk("rst_done",          done,            1'b0);
      chk("rst_done_is_store", done_is_store,   1'b0);
      chk("rst_err_zero_len",  err_zero_len,    1'b0);
      chk("rst_busy",          busy,            1'b0);
      chk("rst_q_count",       q_count,         3'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();

      // Table vectors: single load, wrap-around store, zero-length drop
      for (int i = 0; i < 15; i++) begin
         cyc(tv[i].v, tv[i].c, tv[i].a);
         chk($sformatf("tv%0d_req", i),  line_req,     tv[i].e_req);
         chk($sformatf("tv%0d_done", i), done,         tv[i].e_done);
         chk($sformatf("tv%0d_err", i),  err_zero_len, tv[i].e_err);
         chk($sformatf("tv%0d_qc", i),   q_count,      tv[i].e_qc);
         if (tv[i].e_req) begin
            chk($sformatf("tv%0d_rf", i), line_rf_addr,    tv[i].e_rf);
            chk($sformatf("tv%0d_sd", i), line_sdram_addr, tv[i].e_sd);
         end
         if (tv[i].e_done) chk($sformatf("tv%0d_dst", i), done_is_store, tv[i].e_dst);
      end

      // Backpressure: ack only every third cycle
      obs_ack  = 0;
      obs_done = 0;
      for (int i = 0; i < 30; i++) cyc(i == 0, ca, (i % 3) == 2);
      chk("bp_acks", obs_ack,  3);
      chk("bp_done", obs_done, 1);

      // Fill: no acks, five pushes -> one active, four queued
      for (int i = 0; i < 5; i++) begin
         cx    = ca;
         cx.rf = 10'(i * 16);
         cyc(1'b1, cx, 1'b0);
      end
      chk("fill_q_count",   q_count,   3'd4);
      chk("fill_cmd_ready", cmd_ready, 1'b0);
      chk("fill_line_req",  line_req,  1'b1);
      cyc(1'b1, cs, 1'b0);
      chk("fill_blocked_q_count", q_count, 3'd4);
      obs_done = 0;
      pushed   = 1'b0;
      seen     = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         rdy = cmd_ready;
         cyc(!pushed, cs, 1'b1);
         if (rdy) pushed = 1'b1;
         if (done && done_is_store) seen = 1'b1;
      end
      chk("fill_store_done", seen,     1'b1);
      chk("fill_done_count", obs_done, 6);

      // Maximum line count completes every line
      obs_ack  = 0;
      obs_done = 0;
      cyc(1'b1, cl, 1'b1);
      for (int i = 0; i < 300 && obs_done == 0; i++) cyc(1'b0, cl, 1'b1);
      chk("long_acks", obs_ack,  255);
      chk("long_done", obs_done, 1);

      // Reset after the second ack of a 5-line command, with one queued
      cyc(1'b1, cr, 1'b1);
      cyc(1'b1, ca, 1'b1);
      cyc(1'b0, cr, 1'b1);
      cyc(1'b0, cr, 1'b1);
      chk("pre_rst_rf", line_rf_addr, 10'h102);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_line_req",  line_req,     1'b0);
      chk("mid_rst_q_count",   q_count,      3'd0);
      chk("mid_rst_busy",      busy,         1'b0);
      chk("mid_rst_cmd_ready", cmd_ready,    1'b1);
      chk("mid_rst_rf_addr",   line_rf_addr, 10'h0);
      chk("mid_rst_done",      done,         1'b0);
      model_reset();
      drive(1'b0, cr, 1'b1);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_hold_done",     done,     1'b0);
         chk("rst_hold_line_req", line_req, 1'b0);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      obs_done = 0;
      cyc(1'b1, ca, 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b0, ca, 1'b1);
      chk("post_rst_done", obs_done, 1);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         cx.st     = 1'($urandom);
         cx.rf     = 10'($urandom);
         cx.sd     = $urandom;
         cx.n      = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
         cx.stride = 16'($urandom);
         cyc($urandom_range(0, 99) < 45, cx, $urandom_range(0, 99) < 65);
      end
      for (int i = 0; i < 200 && busy; i++) cyc(1'b0, cx, 1'b1);
      chk("drain_busy", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_rf_ldst_sequencer
`default_nettype wire

// File: doc/rf_ldst_sequencer.md
Name: rf_ldst_sequencer

Overview:
Queued, strided successor to the single-shot RF load/store command path between the control unit and the RF/SDRAM mover. Accepts load/store commands through a valid/ready handshake into a QDEPTH-entry command FIFO. Executes them in order, expanding each into line_num per-line requests with req/ack handshaking. RF address advances by 1 per line; SDRAM address advances by a per-command stride.

Parameters:
RF_ADDR_W, 10, RF line address width
LINE_NUM_W, 8, line count width
SDRAM_ADDR_W, 32, SDRAM address width
STRIDE_W, 16, SDRAM stride width (unsigned, zero-extended)
QDEPTH, 4, command FIFO depth (power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO not full
cmd_is_store  input  1  1=store (RF->SDRAM), 0=load
cmd_rf_addr  input  RF_ADDR_W  first RF line
cmd_sdram_addr  input  SDRAM_ADDR_W  first SDRAM address
cmd_line_num  input  LINE_NUM_W  number of lines
cmd_stride  input  STRIDE_W  SDRAM address increment per line
line_req  output  1  line request valid
line_is_store  output  1  direction of current line
line_rf_addr  output  RF_ADDR_W  current RF line
line_sdram_addr  output  SDRAM_ADDR_W  current SDRAM address
line_ack  input  1  mover accepts current line
done  output  1  one-cycle pulse: command finished
done_is_store  output  1  direction of finished command, valid with done
err_zero_len  output  1  one-cycle pulse: line_num==0 command dropped
busy  output  1  FIFO non-empty or state != IDLE
q_count  output  $clog2(QDEPTH+1)  FIFO occupancy

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: cmd_ready=1, line_req=0, line_is_store=0, all addresses 0, done=0, done_is_store=0, err_zero_len=0, busy=0, q_count=0; FIFO empty; state IDLE.
- Push: handshake when cmd_valid && cmd_ready at a rising edge. cmd_ready = !full. No bypass path; a full FIFO blocks even in a cycle that pops.
- Zero-length commands: line_num==0 is accepted, never enqueued. err_zero_len pulses in the following cycle.
- Simultaneous push and pop: both occur. q_count is unchanged.
- FSM IDLE: if FIFO non-empty, pop the head and load cur_rf, cur_sdram, remaining=line_num, dir; go to ISSUE.
- FSM ISSUE: line_req=1 with registered current fields. Fields are stable while line_ack=0. On line_ack:
  - remaining>1: cur_rf+=1, cur_sdram+=stride, remaining-=1; stay in ISSUE. The next line is presented the next cycle, so back-to-back acks give 1 line/cycle.
  - remaining==1: line_req drops next cycle, done=1 and done_is_store=dir for exactly that cycle, go to IDLE.
- Latency, idle and empty: command accepted at edge t; popped at edge t+1; line_req high in cycle t+2. Between consecutive commands there is one IDLE cycle with line_req=0.
- Arithmetic: cur_rf wraps modulo 2^RF_ADDR_W. cur_sdram wraps modulo 2^SDRAM_ADDR_W. Stride is zero-extended. line_num = 2^LINE_NUM_W-1 must complete all lines.
- line_ack while line_req=0 is ignored.
- Reset mid-operation: FIFO flushed, in-flight command abandoned, no done pulse; outputs return to reset values asynchronously.

Decomposition:
- Package rf_ldst_pkg holds:
  - rf_ldst_cmd_t packed struct {is_store, rf_addr, sdram_addr, line_num, stride}, widths from the package parameter defaults.
  - rf_ldst_state_e enum {IDLE, ISSUE}.
- Sub-module rf_ldst_cmd_fifo: generic synchronous FIFO (parameters WIDTH, DEPTH) with push/pop/full/empty/count. The top instantiates it with the flattened command width.

Test Plan:
- Single load {rf=0x010, sdram=0x1000, n=3, stride=0x40}, line_ack tied 1 -> line_req cycles 2-4 with rf 0x010/0x011/0x012, sdram 0x1000/0x1040/0x1080; done in cycle 5 with done_is_store=0.
- Backpressure: same command, line_ack high only every 3rd cycle -> fields stable while stalled; exactly 3 acks; done once.
- Fill: hold line_ack=0, push 5 commands with QDEPTH=4 -> 1 popped and 4 queued; cmd_ready=0 when q_count=4; a store pushed afterwards completes with done_is_store=1.
- Wrap: rf=0x3FE, sdram=0xFFFF_FFC0, n=3, stride=0x20 -> rf 0x3FE/0x3FF/0x000, sdram 0xFFFF_FFC0/0xFFFF_FFE0/0x0000_0000.
- Zero length: push n=0 -> err_zero_len pulse next cycle; q_count stays 0; no line_req; no done.
- Reset mid-command: assert rst_n=0 after the 2nd ack of an n=5 command -> line_req=0, q_count=0 immediately; no done; a new command afterwards executes normally.
